// File: rtl/text_lcd_receiver.sv
// text_lcd_receiver
//   Receiving end of an HD44780-style 8-bit text-LCD bus. Samples E/RS/RW/DATA,
//   decodes each falling E strobe as a command or a DDRAM character write and
//   mirrors the panel state (2x40 DDRAM, address counter, entry/display/function
//   flags). A registered read port exposes DDRAM contents for checking.
//
// Ports
//   i_clk, i_rst            system clock, synchronous active-high reset
//   i_lcd_e/rs/rw/data      LCD bus (synchronous to i_clk)
//   i_rd_addr / o_rd_char   DDRAM read-back, 1-cycle latency
//   o_wr_strobe/addr/char   pulse + address/character of each DDRAM data write
//   o_cmd_strobe/code       pulse + raw byte of each accepted command
//   o_cur_addr              address counter
//   o_busy                  clear display in progress
//   o_disp_on/cursor_on/blink_on, o_entry_inc, o_func_8bit/func_2line  panel flags
//   o_err                   sticky: [0] strobe while busy, [1] short E, [2] bad address
//
// FSM
//   state   | meaning
//   S_IDLE  | decode bus transfers
//   S_CLEAR | fill DDRAM with CLEAR_CHAR, one cell per cycle, 80 cycles
module text_lcd_receiver #(
    parameter int         MIN_E_HIGH = 1,
    parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_lcd_e,
    input  logic       i_lcd_rs,
    input  logic       i_lcd_rw,
    input  logic [7:0] i_lcd_data,
    input  logic [6:0] i_rd_addr,
    output logic [7:0] o_rd_char,
    output logic       o_wr_strobe,
    output logic [6:0] o_wr_addr,
    output logic [7:0] o_wr_char,
    output logic       o_cmd_strobe,
    output logic [7:0] o_cmd_code,
    output logic [6:0] o_cur_addr,
    output logic       o_busy,
    output logic       o_disp_on,
    output logic       o_cursor_on,
    output logic       o_blink_on,
    output logic       o_entry_inc,
    output logic       o_func_8bit,
    output logic       o_func_2line,
    output logic [2:0] o_err
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    localparam logic [7:0] MIN_E_HIGH_W = 8'(MIN_E_HIGH);
    localparam logic [6:0] CLR_LAST     = 7'd79;

    // input pipeline
    logic       r_q1_e, r_q1_rs, r_q1_rw;
    logic [7:0] r_q1_data;
    logic       r_q2_e, r_q2_rs, r_q2_rw;
    logic [7:0] r_q2_data;
    logic [7:0] r_e_cnt;

    // registered fall event
    logic       r_fall, r_fall_short, r_fall_rs, r_fall_rw;
    logic [7:0] r_fall_data;

    state_t     r_state, w_state_next;
    logic [6:0] r_clr_idx;

    logic [7:0] r_mem [128];
    logic [7:0] r_rd_char;
    logic       r_wr_strobe;
    logic [6:0] r_wr_addr;
    logic [7:0] r_wr_char;
    logic       r_cmd_strobe;
    logic [7:0] r_cmd_code;
    logic [6:0] r_cur_addr;
    logic       r_disp_on, r_cursor_on, r_blink_on, r_entry_inc;
    logic       r_func_8bit, r_func_2line;
    logic [2:0] r_err;

    logic       w_fall, w_busy, w_take, w_take_data, w_take_cmd;
    logic       w_clr_start, w_clr_done;
    logic [6:0] w_clr_addr;
    logic       w_mem_we;
    logic [6:0] w_mem_addr;
    logic [7:0] w_mem_wdata;

    // Address step on the two-line map: 00-27 and 40-67 form one ring.
    function automatic logic [6:0] f_step(input logic [6:0] a, input logic up);
        logic [6:0] r;
        if (up) begin
            if (a == 7'h27)      r = 7'h40;
            else if (a == 7'h67) r = 7'h00;
            else                 r = a + 7'd1;
        end else begin
            if (a == 7'h00)      r = 7'h67;
            else if (a == 7'h40) r = 7'h27;
            else                 r = a - 7'd1;
        end
        return r;
    endfunction

    assign w_fall      = r_q2_e & ~r_q1_e;
    assign w_busy      = (r_state == S_CLEAR);
    assign w_take      = r_fall & ~r_fall_short & ~r_fall_rw & ~w_busy;
    assign w_take_data = w_take & r_fall_rs;
    assign w_take_cmd  = w_take & ~r_fall_rs;
    // clear index 0..39 -> 00..27, 40..79 -> 40..67
    assign w_clr_addr  = (r_clr_idx < 7'd40) ? r_clr_idx : (r_clr_idx + 7'd24);

    // Reset must win over a pending clear or data write.
    assign w_mem_we    = ~i_rst & (w_take_data | w_busy);
    assign w_mem_addr  = w_busy ? w_clr_addr : r_cur_addr;
    assign w_mem_wdata = w_busy ? CLEAR_CHAR : r_fall_data;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q1_e       <= 1'b0;
            r_q1_rs      <= 1'b0;
            r_q1_rw      <= 1'b0;
            r_q1_data    <= 8'h00;
            r_q2_e       <= 1'b0;
            r_q2_rs      <= 1'b0;
            r_q2_rw      <= 1'b0;
            r_q2_data    <= 8'h00;
            r_e_cnt      <= 8'h00;
            r_fall       <= 1'b0;
            r_fall_short <= 1'b0;
            r_fall_rs    <= 1'b0;
            r_fall_rw    <= 1'b0;
            r_fall_data  <= 8'h00;
        end else begin
            r_q1_e       <= i_lcd_e;
            r_q1_rs      <= i_lcd_rs;
            r_q1_rw      <= i_lcd_rw;
            r_q1_data    <= i_lcd_data;
            r_q2_e       <= r_q1_e;
            r_q2_rs      <= r_q1_rs;
            r_q2_rw      <= r_q1_rw;
            r_q2_data    <= r_q1_data;
            if (!r_q1_e)
                r_e_cnt <= 8'h00;
            else if (r_e_cnt != 8'hFF)
                r_e_cnt <= r_e_cnt + 8'd1;
            // q2 still holds the values present while E was high
            r_fall       <= w_fall;
            r_fall_short <= (r_e_cnt < MIN_E_HIGH_W);
            r_fall_rs    <= r_q2_rs;
            r_fall_rw    <= r_q2_rw;
            r_fall_data  <= r_q2_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_clr_start  = 1'b0;
        w_clr_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_take_cmd && (r_fall_data == 8'h01)) begin
                    w_state_next = S_CLEAR;
                    w_clr_start  = 1'b1;
                end
            end
            S_CLEAR: begin
                if (r_clr_idx == CLR_LAST) begin
                    w_state_next = S_IDLE;
                    w_clr_done   = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // DDRAM contents survive reset
    always_ff @(posedge i_clk) begin
        if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_rd_char <= 8'h00;
        else       r_rd_char <= r_mem[i_rd_addr];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_strobe  <= 1'b0;
            r_wr_addr    <= 7'h00;
            r_wr_char    <= 8'h00;
            r_cmd_strobe <= 1'b0;
            r_cmd_code   <= 8'h00;
            r_cur_addr   <= 7'h00;
            r_disp_on    <= 1'b0;
            r_cursor_on  <= 1'b0;
            r_blink_on   <= 1'b0;
            r_entry_inc  <= 1'b1;
            r_func_8bit  <= 1'b0;
            r_func_2line <= 1'b0;
            r_err        <= 3'b000;
            r_clr_idx    <= 7'h00;
        end else begin
            r_wr_strobe  <= 1'b0;
            r_cmd_strobe <= 1'b0;

            if (r_fall && r_fall_short)
                r_err[1] <= 1'b1;
            // reads are ignored outright, even while busy
            if (r_fall && !r_fall_short && !r_fall_rw && w_busy)
                r_err[0] <= 1'b1;

            if (w_take_data) begin
                r_wr_strobe <= 1'b1;
                r_wr_addr   <= r_cur_addr;
                r_wr_char   <= r_fall_data;
                r_cur_addr  <= f_step(r_cur_addr, r_entry_inc);
            end

            if (w_take_cmd) begin
                r_cmd_strobe <= 1'b1;
                r_cmd_code   <= r_fall_data;
                if (r_fall_data[7]) begin
                    // bits [5:0] above 27 cover both holes 28-3F and 68-7F
                    if (r_fall_data[5:0] > 6'h27) begin
                        r_err[2]   <= 1'b1;
                        r_cur_addr <= 7'h00;
                    end else begin
                        r_cur_addr <= r_fall_data[6:0];
                    end
                end else if (r_fall_data[6]) begin
                    // CGRAM address: acknowledged only
                end else if (r_fall_data[5]) begin
                    r_func_8bit  <= r_fall_data[4];
                    r_func_2line <= r_fall_data[3];
                end else if (r_fall_data[4]) begin
                    if (!r_fall_data[3])
                        r_cur_addr <= f_step(r_cur_addr, r_fall_data[2]);
                end else if (r_fall_data[3]) begin
                    r_disp_on   <= r_fall_data[2];
                    r_cursor_on <= r_fall_data[1];
                    r_blink_on  <= r_fall_data[0];
                end else if (r_fall_data[2]) begin
                    r_entry_inc <= r_fall_data[1];
                end else if (r_fall_data[1]) begin
                    r_cur_addr <= 7'h00;
                end
                // 01 handled by the FSM, 00 is a no-op
            end

            if (w_clr_start)
                r_clr_idx <= 7'h00;
            else if (w_busy)
                r_clr_idx <= r_clr_idx + 7'd1;

            if (w_clr_done) begin
                r_cur_addr  <= 7'h00;
                r_entry_inc <= 1'b1;
            end
        end
    end

    assign o_rd_char    = r_rd_char;
    assign o_wr_strobe  = r_wr_strobe;
    assign o_wr_addr    = r_wr_addr;
    assign o_wr_char    = r_wr_char;
    assign o_cmd_strobe = r_cmd_strobe;
    assign o_cmd_code   = r_cmd_code;
    assign o_cur_addr   = r_cur_addr;
    assign o_busy       = w_busy;
    assign o_disp_on    = r_disp_on;
    assign o_cursor_on  = r_cursor_on;
    assign o_blink_on   = r_blink_on;
    assign o_entry_inc  = r_entry_inc;
    assign o_func_8bit  = r_func_8bit;
    assign o_func_2line = r_func_2line;
    assign o_err        = r_err;

endmodule
